// File: rtl/rv_pkg.sv
// Shared register-file definitions: default sizes and the common data/address types.
package rv_pkg;

  localparam int RV_XLEN  = 32;
  localparam int RV_NREGS = 32;
  localparam int RV_AW    = $clog2(RV_NREGS);

  typedef logic [RV_XLEN-1:0] xlen_t;
  typedef logic [RV_AW-1:0]   regaddr_t;

endpackage

// File: rtl/regfile_scoreboard_if.sv
// Bus bundle for the register file: read ports, write ports and the issue strobe.
interface regfile_scoreboard_if #(
  parameter int XLEN  = 32,
  parameter int NREGS = 32,
  parameter int NRD   = 2,
  parameter int NWR   = 2
);
  localparam int AW = $clog2(NREGS);

  logic [NRD-1:0][AW-1:0]   rd_addr;
  logic [NRD-1:0][XLEN-1:0] rd_data;
  logic [NRD-1:0]           rd_busy;
  logic [NWR-1:0]           wr_en;
  logic [NWR-1:0][AW-1:0]   wr_addr;
  logic [NWR-1:0][XLEN-1:0] wr_data;
  logic                     iss_en;
  logic [AW-1:0]            iss_rd;

  modport master (
    output rd_addr, wr_en, wr_addr, wr_data, iss_en, iss_rd,
    input  rd_data, rd_busy
  );

  modport slave (
    input  rd_addr, wr_en, wr_addr, wr_data, iss_en, iss_rd,
    output rd_data, rd_busy
  );
endinterface

// File: rtl/rf_scoreboard.sv
// Pending-producer tracker: one busy bit per register, set by issue, cleared by writeback.
module rf_scoreboard
  import rv_pkg::*;
#(
  parameter int  NREGS = RV_NREGS,
  parameter int  NRD   = 2,
  parameter int  NWR   = 2,
  localparam int AW    = $clog2(NREGS)
) (
  input  logic                   clock,
  input  logic                   reset_n,
  input  logic [NRD-1:0][AW-1:0] i_rd_addr,
  input  logic [NWR-1:0]         i_wr_en,
  input  logic [NWR-1:0][AW-1:0] i_wr_addr,
  input  logic                   i_iss_en,
  input  logic [AW-1:0]          i_iss_rd,
  output logic [NRD-1:0]         o_rd_busy
);

  logic [NREGS-1:0] r_busy;
  logic [NRD-1:0]   w_wr_hit;

  // Writeback clears, then issue sets last so a same-cycle issue (newer producer) wins.
  always_ff @(posedge clock) begin
    if (!reset_n) begin
      r_busy <= '0;
    end else begin
      for (int w = 0; w < NWR; w++) begin
        if (i_wr_en[w]) r_busy[i_wr_addr[w]] <= 1'b0;
      end
      if (i_iss_en && (i_iss_rd != '0)) r_busy[i_iss_rd] <= 1'b1;
    end
  end

  // Busy seen by a reader is masked by a same-cycle write, matching the data bypass.
  always_comb begin
    w_wr_hit  = '0;
    o_rd_busy = '0;
    for (int p = 0; p < NRD; p++) begin
      for (int w = 0; w < NWR; w++) begin
        if (i_wr_en[w] && (i_wr_addr[w] == i_rd_addr[p])) w_wr_hit[p] = 1'b1;
      end
      o_rd_busy[p] = r_busy[i_rd_addr[p]] & ~w_wr_hit[p];
    end
  end

endmodule

// File: rtl/regfile_scoreboard.sv
// Multi-ported register file with write bypass and an attached busy scoreboard.
module regfile_scoreboard
  import rv_pkg::*;
#(
  parameter int XLEN  = RV_XLEN,
  parameter int NREGS = RV_NREGS,
  parameter int NRD   = 2,
  parameter int NWR   = 2
) (
  input  logic                 clock,
  input  logic                 reset_n,
  regfile_scoreboard_if.slave  bus
);

  localparam int AW = $clog2(NREGS);

  logic [XLEN-1:0]          r_regs [NREGS];
  logic [NRD-1:0][XLEN-1:0] w_rd_data;

  // Commit writes; later ports overwrite earlier ones so the highest index wins. x0 is never written.
  always_ff @(posedge clock) begin
    if (!reset_n) begin
      for (int i = 0; i < NREGS; i++) r_regs[i] <= '0;
    end else begin
      for (int w = 0; w < NWR; w++) begin
        if (bus.wr_en[w] && (bus.wr_addr[w] != '0)) r_regs[bus.wr_addr[w]] <= bus.wr_data[w];
      end
    end
  end

  // Read mux with same-cycle bypass; highest-index matching write port takes precedence.
  always_comb begin
    w_rd_data = '0;
    for (int p = 0; p < NRD; p++) begin
      if (bus.rd_addr[p] != '0) begin
        w_rd_data[p] = r_regs[bus.rd_addr[p]];
        for (int w = 0; w < NWR; w++) begin
          if (bus.wr_en[w] && (bus.wr_addr[w] == bus.rd_addr[p])) w_rd_data[p] = bus.wr_data[w];
        end
      end
    end
  end

  assign bus.rd_data = w_rd_data;

  rf_scoreboard #(
    .NREGS (NREGS),
    .NRD   (NRD),
    .NWR   (NWR)
  ) u_scoreboard (
    .clock     (clock),
    .reset_n   (reset_n),
    .i_rd_addr (bus.rd_addr),
    .i_wr_en   (bus.wr_en),
    .i_wr_addr (bus.wr_addr),
    .i_iss_en  (bus.iss_en),
    .i_iss_rd  (bus.iss_rd),
    .o_rd_busy (bus.rd_busy)
  );

endmodule

// File: tb/tb_regfile_scoreboard.sv
// Directed bench: stimulus pushes expected read results, a negedge monitor pops and compares.
module tb_regfile_scoreboard;
  import rv_pkg::*;

  localparam int XLEN  = 32;
  localparam int NREGS = 32;
  localparam int NRD   = 2;
  localparam int NWR   = 2;

  typedef struct {
    logic [127:0] name;
    int           port;
    xlen_t        data;
    logic         busy;
  } exp_t;

  logic clock;
  logic reset_n;
  exp_t exp_q[$];
  int   n_checks;
  int   n_fail;

  regfile_scoreboard_if #(.XLEN(XLEN), .NREGS(NREGS), .NRD(NRD), .NWR(NWR)) bus ();

  regfile_scoreboard #(.XLEN(XLEN), .NREGS(NREGS), .NRD(NRD), .NWR(NWR)) dut (
    .clock   (clock),
    .reset_n (reset_n),
    .bus     (bus)
  );

  initial clock = 1'b0;
  always #5 clock = ~clock;

  task automatic idle();
    bus.rd_addr = '0;
    bus.wr_en   = '0;
    bus.wr_addr = '0;
    bus.wr_data = '0;
    bus.iss_en  = 1'b0;
    bus.iss_rd  = '0;
  endtask

  // Move to the drive point of the next cycle and clear all strobes.
  task automatic next_cycle();
    @(posedge clock);
    #1;
    idle();
  endtask

  task automatic expect_rd(input logic [127:0] name, input int port, input xlen_t data,
                           input logic busy);
    exp_t e;
    e.name = name;
    e.port = port;
    e.data = data;
    e.busy = busy;
    exp_q.push_back(e);
  endtask

  task automatic wr(input int port, input int addr, input xlen_t data);
    bus.wr_en[port]   = 1'b1;
    bus.wr_addr[port] = addr[4:0];
    bus.wr_data[port] = data;
  endtask

  task automatic rd(input int port, input int addr);
    bus.rd_addr[port] = addr[4:0];
  endtask

  // Monitor: compare every queued expectation against the read ports mid-cycle.
  initial begin
    exp_t e;
    xlen_t got_d;
    logic  got_b;
    n_checks = 0;
    n_fail   = 0;
    forever begin
      @(negedge clock);
      while (exp_q.size() > 0) begin
        e     = exp_q.pop_front();
        got_d = bus.rd_data[e.port];
        got_b = bus.rd_busy[e.port];
        n_checks++;
        if (got_d !== e.data) begin
          n_fail++;
          $display("FAIL %0s data port%0d: got %h expected %h", e.name, e.port, got_d, e.data);
        end
        n_checks++;
        if (got_b !== e.busy) begin
          n_fail++;
          $display("FAIL %0s busy port%0d: got %b expected %b", e.name, e.port, got_b, e.busy);
        end
      end
    end
  end

  initial begin
    int waited;
    reset_n = 1'b0;
    idle();
    repeat (2) @(posedge clock);
    #1;
    reset_n = 1'b1;

    // Post-reset sweep of every address on both ports.
    for (int a = 0; a < NREGS; a++) begin
      next_cycle();
      rd(0, a);
      rd(1, NREGS - 1 - a);
      expect_rd("rst_sweep", 0, 32'h0, 1'b0);
      expect_rd("rst_sweep", 1, 32'h0, 1'b0);
    end

    // Bypass then commit of x5.
    next_cycle();
    wr(0, 5, 32'hDEADBEEF);
    rd(0, 5); rd(1, 5);
    expect_rd("x5_bypass", 0, 32'hDEADBEEF, 1'b0);
    expect_rd("x5_bypass", 1, 32'hDEADBEEF, 1'b0);
    next_cycle();
    rd(0, 5); rd(1, 6);
    expect_rd("x5_commit", 0, 32'hDEADBEEF, 1'b0);
    expect_rd("x6_untouched", 1, 32'h0, 1'b0);

    // Same-address write collision on x7: port 1 wins.
    next_cycle();
    wr(0, 7, 32'h1);
    wr(1, 7, 32'h2);
    rd(0, 7); rd(1, 5);
    expect_rd("x7_prio_bypass", 0, 32'h2, 1'b0);
    expect_rd("x5_other_port", 1, 32'hDEADBEEF, 1'b0);
    next_cycle();
    rd(0, 5); rd(1, 7);
    expect_rd("x7_prio_commit", 1, 32'h2, 1'b0);
    expect_rd("x5_hold", 0, 32'hDEADBEEF, 1'b0);

    // Issue x9, observe busy, then writeback clears it with bypassed data.
    next_cycle();
    bus.iss_en = 1'b1; bus.iss_rd = 5'd9;
    rd(0, 9);
    expect_rd("x9_issue_cycle", 0, 32'h0, 1'b0);
    next_cycle();
    rd(0, 9); rd(1, 9);
    expect_rd("x9_busy", 0, 32'h0, 1'b1);
    expect_rd("x9_busy", 1, 32'h0, 1'b1);
    next_cycle();
    wr(1, 9, 32'h55);
    rd(0, 9);
    expect_rd("x9_wb", 0, 32'h55, 1'b0);
    next_cycle();
    rd(0, 9);
    expect_rd("x9_after_wb", 0, 32'h55, 1'b0);

    // x3 busy, then re-issue and write x3 in the same cycle: stays busy.
    next_cycle();
    bus.iss_en = 1'b1; bus.iss_rd = 5'd3;
    next_cycle();
    rd(0, 3);
    expect_rd("x3_busy", 0, 32'h0, 1'b1);
    next_cycle();
    bus.iss_en = 1'b1; bus.iss_rd = 5'd3;
    wr(0, 3, 32'hA5A5A5A5);
    rd(0, 3);
    expect_rd("x3_iss_wb", 0, 32'hA5A5A5A5, 1'b0);
    next_cycle();
    rd(0, 3); rd(1, 3);
    expect_rd("x3_rebusy", 0, 32'hA5A5A5A5, 1'b1);
    expect_rd("x3_rebusy", 1, 32'hA5A5A5A5, 1'b1);

    // x0 ignores writes and issues.
    next_cycle();
    wr(0, 0, 32'hFFFFFFFF);
    wr(1, 0, 32'hFFFFFFFF);
    bus.iss_en = 1'b1; bus.iss_rd = 5'd0;
    rd(0, 0); rd(1, 0);
    expect_rd("x0_bypass", 0, 32'h0, 1'b0);
    expect_rd("x0_bypass", 1, 32'h0, 1'b0);
    next_cycle();
    rd(0, 0);
    expect_rd("x0_after", 0, 32'h0, 1'b0);

    // Make x9 busy, then reset mid-operation with a concurrent write and issue.
    next_cycle();
    bus.iss_en = 1'b1; bus.iss_rd = 5'd9;
    next_cycle();
    rd(0, 9); rd(1, 3);
    expect_rd("x9_prereset", 0, 32'h55, 1'b1);
    expect_rd("x3_prereset", 1, 32'hA5A5A5A5, 1'b1);
    next_cycle();
    reset_n = 1'b0;
    wr(0, 12, 32'h77);
    bus.iss_en = 1'b1; bus.iss_rd = 5'd12;
    next_cycle();
    reset_n = 1'b1;
    rd(0, 9); rd(1, 3);
    expect_rd("x9_postreset", 0, 32'h0, 1'b0);
    expect_rd("x3_postreset", 1, 32'h0, 1'b0);
    next_cycle();
    rd(0, 12); rd(1, 5);
    expect_rd("x12_postreset", 0, 32'h0, 1'b0);
    expect_rd("x5_postreset", 1, 32'h0, 1'b0);
    next_cycle();
    rd(0, 7);
    expect_rd("x7_postreset", 0, 32'h0, 1'b0);

    waited = 0;
    while (exp_q.size() > 0 && waited < 10) begin
      @(posedge clock);
      waited++;
    end
    if (exp_q.size() > 0) begin
      n_fail++;
      $display("FAIL drain: %0d expectations left unchecked, required 0", exp_q.size());
    end
    #1;
    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule
